edge_trigger: RTL and testbench
===============================

Name: edge_trigger

Overview:
- Synchronising edge detector that emits a clean, fixed-length, active-high pulse whenever its input changes (per the configured edge mode).
- Sits in front of a debouncer. Its pulse restarts the debouncer's settle timer on every input transition.
- Fully clock-synchronous apart from the asynchronous reset.

Parameters:
- SYNC_STAGES, 2, number of synchroniser flops on `in`; legal range 1..4.
- EDGE_MODE, 0, selects which transitions trigger: 0 = both, 1 = rising only, 2 = falling only; 3 is illegal (elaboration error).
- PULSE_LEN, 1, width of the output pulse in clock cycles; legal range 1..255.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- in  input  1  raw, possibly asynchronous, level input.
- out  output  1  registered trigger pulse, active-high.

Behaviour:
- Reset: clears all synchroniser flops, the previous-sample register `prev`, the pulse counter and `out` to 0.
- Because `prev` resets to 0, an `in` held at 1 through reset release produces one rising-edge pulse (modes 0 and 1).
- Synchroniser: `in` passes through SYNC_STAGES flops. Let `s` be the last stage.
- Every cycle `prev <= s`.
- Edge detect (combinational, from current register state):
  - rise = s & ~prev
  - fall = ~s & prev
  - hit = (rise|fall), rise or fall according to EDGE_MODE.
- Pulse generation uses counter `cnt`, 8 bits:
  - If hit: `cnt <= PULSE_LEN-1` and `out <= 1`.
  - Else if `cnt != 0`: `cnt <= cnt-1` and `out <= 1`.
  - Else `out <= 0`.
- Latency: `in` changes and is stable before rising edge E1. `out` goes high after edge E(SYNC_STAGES+1), i.e. 3 cycles for the default. It stays high for exactly PULSE_LEN cycles.
- Retrigger: a hit while `out` is already high reloads `cnt`. The pulse is extended to PULSE_LEN cycles from the new hit, with no low gap.
- Glitch: an input pulse shorter than one clock period may be missed. If captured by stage 1, it yields two hits in consecutive cycles (mode 0). This is merged by the retrigger rule.
- Reset mid-pulse: `out` drops to 0 immediately (asynchronously).
- `out` never glitches: it is driven only from a flop.

Optional Feature:
- Macro: EDGE_TRIGGER_COUNT_EN.
- With the macro defined:
  - An extra output port `edge_count`, 16 bits, is present.
  - It increments by 1 on every cycle where hit=1 and wraps from 0xFFFF to 0.
  - Reset clears it to 0.
- Without the macro: the port and counter do not exist, and behaviour is otherwise identical.

Decomposition:
- Package `edge_trigger_pkg` holds:
  - localparams EDGE_BOTH=0, EDGE_RISE=1, EDGE_FALL=2;
  - CNT_W=8 and EDGE_CNT_W=16.
- One sub-module: `sync_chain` (parameter STAGES, ports clock/reset/d/q), a reset-to-0 flop chain.
- Edge detect and pulse logic live in `edge_trigger`.

Test Plan:
- Reset, default params, `in`=0 held 10 cycles → `out`=0 throughout.
- Defaults: `in` 0→1 before E1 → `out`=1 only in the cycle after E3, then 0. `in` 1→0 later → the same single pulse.
- EDGE_MODE=1, PULSE_LEN=4: `in` rises → `out` high exactly 4 cycles. `in` falls → `out` stays 0.
- PULSE_LEN=4: rising edge, then falling edge 2 cycles later (mode 0) → `out` high continuously for 2+4=6 cycles.
- `in`=1 during reset, reset released → exactly one pulse, SYNC_STAGES+1 cycles after release. Assert reset mid-pulse → `out` 0 immediately.
- EDGE_TRIGGER_COUNT_EN defined: toggle `in` 5 times with 10-cycle spacing → `edge_count`=5. Preload via 65536 toggles → wraps to 0.

Source files
------------

// File: rtl/edge_trigger_pkg.sv
// Shared constants for the edge_trigger block: edge-mode encodings and counter widths.
// Optional edge counter is enabled with EDGE_TRIGGER_COUNT_EN.
package edge_trigger_pkg;
  localparam int EDGE_BOTH  = 0;
  localparam int EDGE_RISE  = 1;
  localparam int EDGE_FALL  = 2;
  localparam int CNT_W      = 8;
  localparam int EDGE_CNT_W = 16;
endpackage

// File: rtl/edge_trigger_if.sv
// Level input / trigger pulse bundle of edge_trigger.
// The edge_count member exists only when EDGE_TRIGGER_COUNT_EN is defined.
interface edge_trigger_if;
  import edge_trigger_pkg::*;
  logic in;
  logic out;
`ifdef EDGE_TRIGGER_COUNT_EN
  logic [EDGE_CNT_W-1:0] edge_count;

  modport master (output in, input out, input edge_count);
  modport slave  (input in, output out, output edge_count);
`else
  modport master (output in, input out);
  modport slave  (input in, output out);
`endif
endinterface

// File: rtl/sync_chain.sv
// Reset-to-0 flop chain used to synchronise an asynchronous level input.
module sync_chain #(
  parameter int STAGES = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);
  logic [STAGES-1:0] stage_q;
  logic [STAGES-1:0] stage_d;

  always_comb begin
    stage_d    = stage_q;
    stage_d[0] = d;
    for (int i = 1; i < STAGES; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) stage_q <= '0;
    else       stage_q <= stage_d;
  end

  assign q = stage_q[STAGES-1];
endmodule

// File: rtl/edge_trigger.sv
// Synchronising edge detector producing a fixed-length, retriggerable output pulse.
// Define EDGE_TRIGGER_COUNT_EN to add a wrapping 16-bit count of detected edges.
module edge_trigger
  import edge_trigger_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_MODE   = 0,
  parameter int PULSE_LEN   = 1
) (
  input logic          clock,
  input logic          reset,
  edge_trigger_if.slave bus
);
  if (SYNC_STAGES < 1 || SYNC_STAGES > 4) begin : g_bad_sync
    $error("edge_trigger: SYNC_STAGES must be 1..4");
  end
  if (EDGE_MODE < EDGE_BOTH || EDGE_MODE > EDGE_FALL) begin : g_bad_mode
    $error("edge_trigger: EDGE_MODE must be 0, 1 or 2");
  end
  if (PULSE_LEN < 1 || PULSE_LEN > 255) begin : g_bad_len
    $error("edge_trigger: PULSE_LEN must be 1..255");
  end

  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(PULSE_LEN - 1);

  logic             s;
  logic             prev_q, prev_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             out_q, out_d;
  logic             rise, fall, hit;

  sync_chain #(.STAGES(SYNC_STAGES)) u_sync (
    .clock (clock),
    .reset (reset),
    .d     (bus.in),
    .q     (s)
  );

  always_comb begin
    prev_d = s;
    rise   = s & ~prev_q;
    fall   = ~s & prev_q;
    if (EDGE_MODE == EDGE_RISE)      hit = rise;
    else if (EDGE_MODE == EDGE_FALL) hit = fall;
    else                             hit = rise | fall;

    // A hit always reloads, so a retrigger stretches the pulse with no low gap.
    cnt_d = cnt_q;
    out_d = 1'b0;
    if (hit) begin
      cnt_d = RELOAD;
      out_d = 1'b1;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
      out_d = 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      prev_q <= 1'b0;
      cnt_q  <= '0;
      out_q  <= 1'b0;
    end else begin
      prev_q <= prev_d;
      cnt_q  <= cnt_d;
      out_q  <= out_d;
    end
  end

  assign bus.out = out_q;

`ifdef EDGE_TRIGGER_COUNT_EN
  logic [EDGE_CNT_W-1:0] edge_cnt_q, edge_cnt_d;

  always_comb begin
    edge_cnt_d = edge_cnt_q + EDGE_CNT_W'(hit);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) edge_cnt_q <= '0;
    else       edge_cnt_q <= edge_cnt_d;
  end

  assign bus.edge_count = edge_cnt_q;
`endif
endmodule

// File: tb/tb_edge_trigger.sv
// Randomised and directed checks of edge_trigger against an edge-history reference model.
module tb_edge_trigger;
  localparam int NDUT = 4;
  localparam int P_SYNC [NDUT] = '{2, 2, 2, 3};
  localparam int P_MODE [NDUT] = '{0, 1, 0, 2};
  localparam int P_LEN  [NDUT] = '{1, 4, 4, 2};

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic din   = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clock = ~clock;

  edge_trigger_if bus0 ();
  edge_trigger_if bus1 ();
  edge_trigger_if bus2 ();
  edge_trigger_if bus3 ();
  assign bus0.in = din;
  assign bus1.in = din;
  assign bus2.in = din;
  assign bus3.in = din;

  edge_trigger #(.SYNC_STAGES(2), .EDGE_MODE(0), .PULSE_LEN(1)) dut0 (.clock(clock), .reset(reset), .bus(bus0));
  edge_trigger #(.SYNC_STAGES(2), .EDGE_MODE(1), .PULSE_LEN(4)) dut1 (.clock(clock), .reset(reset), .bus(bus1));
  edge_trigger #(.SYNC_STAGES(2), .EDGE_MODE(0), .PULSE_LEN(4)) dut2 (.clock(clock), .reset(reset), .bus(bus2));
  edge_trigger #(.SYNC_STAGES(3), .EDGE_MODE(2), .PULSE_LEN(2)) dut3 (.clock(clock), .reset(reset), .bus(bus3));

  // Reference: per clock edge since reset, record whether the sampled input rose (bit0) or fell (bit1).
  // A transition sampled at edge j drives out high after edges j+S .. j+S+L-1.
  byte unsigned trig_q[$];
  bit           last_s;
  int unsigned  hits [NDUT];

  function automatic bit match(byte unsigned t, int mode);
    if (mode == 1) return t[0];
    if (mode == 2) return t[1];
    return t != 0;
  endfunction

  function automatic logic exp_out(int k);
    int n;
    n = trig_q.size() - 1;
    for (int j = n - P_SYNC[k] - P_LEN[k] + 1; j <= n - P_SYNC[k]; j++)
      if (j >= 0 && match(trig_q[j], P_MODE[k])) return 1'b1;
    return 1'b0;
  endfunction

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      trig_q.delete();
      last_s = 1'b0;
      for (int k = 0; k < NDUT; k++) hits[k] = 0;
    end else begin
      trig_q.push_back({6'd0, ~din & last_s, din & ~last_s});
      last_s = din;
      for (int k = 0; k < NDUT; k++) begin
        int j;
        j = trig_q.size() - 1 - P_SYNC[k];
        if (j >= 0 && match(trig_q[j], P_MODE[k])) hits[k]++;
      end
    end
  end

  task automatic check(string tag, logic [15:0] obs, logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    check("out0", {15'd0, bus0.out}, {15'd0, exp_out(0)});
    check("out1", {15'd0, bus1.out}, {15'd0, exp_out(1)});
    check("out2", {15'd0, bus2.out}, {15'd0, exp_out(2)});
    check("out3", {15'd0, bus3.out}, {15'd0, exp_out(3)});
`ifdef EDGE_TRIGGER_COUNT_EN
    check("cnt0", bus0.edge_count, hits[0][15:0]);
    check("cnt1", bus1.edge_count, hits[1][15:0]);
    check("cnt2", bus2.edge_count, hits[2][15:0]);
    check("cnt3", bus3.edge_count, hits[3][15:0]);
`endif
  endtask

  // kind: 0 hold, 1 random level each cycle, 2 toggle each cycle, 3 sparse random toggles
  task automatic run(int n, int kind);
    repeat (n) begin
      @(negedge clock);
      check_all();
      case (kind)
        1: din = 1'($urandom_range(0, 1));
        2: din = ~din;
        3: if ($urandom_range(0, 7) == 0) din = ~din;
        default: ;
      endcase
    end
  endtask

  initial begin
    reset = 1'b1;
    din   = 1'b0;
    repeat (3) @(negedge clock);
    check_all();
    reset = 1'b0;
    run(10, 0);

    din = 1'b1;
    run(10, 0);
    din = 1'b0;
    run(10, 0);

    din = 1'b1;
    run(2, 0);
    din = 1'b0;
    run(10, 0);

    run(300, 1);
    run(300, 3);

    din   = 1'b1;
    reset = 1'b1;
    run(3, 0);
    reset = 1'b0;
    run(4, 0);
    reset = 1'b1;
    #1;
    check("rst_mid_out2", {15'd0, bus2.out}, 16'd0);
    check_all();
    run(2, 0);
    reset = 1'b0;
    run(10, 0);
    din = 1'b0;
    run(10, 0);

`ifdef EDGE_TRIGGER_COUNT_EN
    reset = 1'b1;
    run(2, 0);
    reset = 1'b0;
    run(5, 0);
    repeat (5) begin
      din = ~din;
      run(10, 0);
    end
    check("count5", bus0.edge_count, 16'd5);
    run(65531, 2);
    run(10, 0);
    check("wrap", bus0.edge_count, 16'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
